// File: rtl/uart_slip_pkg.sv
// SLIP framing constants, decoder state encoding and the output beat record
// shared by the SLIP decoder.
package uart_slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_ESCAPE = 1'b1
    } slip_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } axis_beat_t;

endpackage

// File: rtl/uart_slip_decoder.sv
// SLIP decoder: UART byte stream in, AXI-Stream packets out through a one-byte
// hold register and a registered output stage. Define UART_SLIP_MAX_LEN_EN to enable MAX_LEN truncation.
module uart_slip_decoder
    import uart_slip_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_frame_error,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    if (MAX_LEN < 1) begin : g_max_len_check
        $error("MAX_LEN must be at least 1");
    end

    slip_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        err_q, err_d;
    axis_beat_t  out_q, out_d;
    logic        out_vld_q, out_vld_d;
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] errc_q, errc_d;

    logic        accept;
    logic        prod_vld;
    logic [7:0]  prod_byte;
    logic        is_end;
    logic        bad_esc;
    logic        keep;
    logic        err_set;

`ifdef UART_SLIP_MAX_LEN_EN
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic [LEN_W-1:0] len_q, len_d;
`endif

    // The output slot can take a new beat if it is empty or draining this cycle.
    assign s_axis_tready = !out_vld_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        state_d = state_q;
        if (accept) begin
            if (state_q == ST_NORMAL && s_axis_tdata == SLIP_ESC) state_d = ST_ESCAPE;
            else                                                 state_d = ST_NORMAL;
        end
    end

    // Byte decode for the current state.
    always_comb begin
        prod_vld  = 1'b0;
        prod_byte = s_axis_tdata;
        is_end    = 1'b0;
        bad_esc   = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (s_axis_tdata == SLIP_END)      is_end   = 1'b1;
                    else if (s_axis_tdata != SLIP_ESC) prod_vld = 1'b1;
                end
                ST_ESCAPE: begin
                    unique case (s_axis_tdata)
                        SLIP_ESC_END: begin prod_vld = 1'b1; prod_byte = SLIP_END; end
                        SLIP_ESC_ESC: begin prod_vld = 1'b1; prod_byte = SLIP_ESC; end
                        SLIP_END:     begin is_end   = 1'b1; bad_esc   = 1'b1;     end
                        default:      begin prod_vld = 1'b1; bad_esc   = 1'b1;     end
                    endcase
                end
            endcase
        end
    end

    // Hold register, output register, error flag and counters.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        err_d      = err_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        pkt_d      = pkt_q;
        errc_d     = errc_q;
        keep       = prod_vld;
        err_set    = s_frame_error || bad_esc;
`ifdef UART_SLIP_MAX_LEN_EN
        len_d = len_q;
        if (prod_vld) begin
            if (len_q >= LEN_W'(MAX_LEN)) begin
                keep    = 1'b0;
                err_set = 1'b1;
            end else begin
                len_d = len_q + LEN_W'(1);
            end
        end
        if (is_end) len_d = '0;
`endif

        if (out_vld_q && m_axis_tready) begin
            out_vld_d = 1'b0;
            if (out_q.last) begin
                pkt_d = pkt_q + 16'd1;
                if (out_q.user) errc_d = errc_q + 16'd1;
            end
        end

        // A new byte displaces the held one; END flushes it as the last beat.
        if (keep) begin
            if (hold_vld_q) begin
                out_d     = '{data: hold_q, last: 1'b0, user: 1'b0};
                out_vld_d = 1'b1;
            end
            hold_d     = prod_byte;
            hold_vld_d = 1'b1;
        end

        if (is_end) begin
            if (hold_vld_q) begin
                out_d     = '{data: hold_q, last: 1'b1, user: err_q || err_set};
                out_vld_d = 1'b1;
            end
            hold_vld_d = 1'b0;
            err_d      = 1'b0;
        end else begin
            err_d = err_q || err_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            pkt_q      <= '0;
            errc_q     <= '0;
`ifdef UART_SLIP_MAX_LEN_EN
            len_q      <= '0;
`endif
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            err_q      <= err_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            pkt_q      <= pkt_d;
            errc_q     <= errc_d;
`ifdef UART_SLIP_MAX_LEN_EN
            len_q      <= len_d;
`endif
        end
    end

    assign m_axis_tdata  = out_q.data;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tvalid = out_vld_q;
    assign busy          = hold_vld_q || (state_q == ST_ESCAPE);
    assign pkt_count     = pkt_q;
    assign err_count     = errc_q;

endmodule

// File: tb/tb_uart_slip_decoder.sv
// Scoreboard bench for uart_slip_decoder: expected beats are queued as bytes are
// driven and compared as the DUT transfers them. Define UART_SLIP_MAX_LEN_EN for the MAX_LEN=4 case.
module tb_uart_slip_decoder;
    import uart_slip_pkg::*;

`ifdef UART_SLIP_MAX_LEN_EN
    localparam int unsigned TB_MAX_LEN = 4;
`else
    localparam int unsigned TB_MAX_LEN = 1500;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_frame_error = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    uart_slip_decoder #(.MAX_LEN(TB_MAX_LEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_frame_error (s_frame_error),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         beats_seen = 0;
    int         exp_pkts = 0;
    int         exp_errs = 0;
    bit         rand_ready = 1'b0;
    axis_beat_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic last, input logic user);
        exp_q.push_back('{data: d, last: last, user: user});
        if (last) begin
            exp_pkts++;
            if (user) exp_errs++;
        end
    endtask

    // Drive one byte and hold it until the DUT accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("send_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (n >= 600) check("drain_timeout", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts[15:0]));
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_errs[15:0]));
    endtask

    // Output monitor: a beat transfers at the next rising edge when valid and ready.
    initial begin
        axis_beat_t e;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_axis_tdata), 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                          {22'd0, e.data, e.last, e.user});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pay[$];
        int         len;
        int         beats_before;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_tready", 32'(s_axis_tready), 1);
        check_counters("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain packet.
        expect_beat(8'h41, 1'b0, 1'b0);
        expect_beat(8'h42, 1'b1, 1'b0);
        foreach (pay[i]) pay.delete(i);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'hC0);
        drain();
        check_counters("plain");

        // Both escape sequences.
        expect_beat(8'hC0, 1'b0, 1'b0);
        expect_beat(8'hDB, 1'b1, 1'b0);
        send_byte(8'hDB); send_byte(8'hDC); send_byte(8'hDB); send_byte(8'hDD); send_byte(8'hC0);
        drain();
        check_counters("escapes");

        // Bad escape passes the raw byte and flags the packet.
        expect_beat(8'h10, 1'b0, 1'b0);
        expect_beat(8'h55, 1'b1, 1'b1);
        send_byte(8'h10); send_byte(8'hDB); send_byte(8'h55); send_byte(8'hC0);
        drain();
        check_counters("bad_esc");

        // Empty packets vanish.
        expect_beat(8'h01, 1'b1, 1'b0);
        send_byte(8'hC0); send_byte(8'hC0); send_byte(8'h01); send_byte(8'hC0);
        drain();
        check_counters("empty");

        // ESC followed by END closes the packet as bad; busy tracks hold and ESCAPE.
        expect_beat(8'h05, 1'b1, 1'b1);
        send_byte(8'h05);
        check("busy_hold", 32'(busy), 1);
        send_byte(8'hDB);
        check("busy_escape", 32'(busy), 1);
        send_byte(8'hC0);
        drain();
        check("busy_idle", 32'(busy), 0);
        check_counters("esc_end");

        // Stall mid-packet with a framing error during the stall.
        m_axis_tready = 1'b0;
        expect_beat(8'h11, 1'b0, 1'b0);
        expect_beat(8'h22, 1'b0, 1'b0);
        expect_beat(8'h33, 1'b1, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        s_axis_tdata  = 8'h33;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_tready", 32'(s_axis_tready), 0);
            check("stall_tvalid", 32'(m_axis_tvalid), 1);
            check("stall_tdata", 32'(m_axis_tdata), 32'h11);
            check("stall_tlast", 32'(m_axis_tlast), 0);
            @(posedge clk);
            #1;
            s_frame_error = (i == 1);
        end
        s_frame_error = 1'b0;
        m_axis_tready = 1'b1;
        send_byte(8'h33);
        send_byte(8'hC0);
        drain();
        check_counters("stall");

        // Random payloads, SLIP-encoded here, under random backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 4);
            pay.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 4))
                    0: pay.push_back(SLIP_END);
                    1: pay.push_back(SLIP_ESC);
                    2: pay.push_back(SLIP_ESC_END);
                    default: pay.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            for (int i = 0; i < len; i++) expect_beat(pay[i], i == len - 1, 1'b0);
            for (int i = 0; i < len; i++) begin
                if (pay[i] == SLIP_END)      begin send_byte(SLIP_ESC); send_byte(SLIP_ESC_END); end
                else if (pay[i] == SLIP_ESC) begin send_byte(SLIP_ESC); send_byte(SLIP_ESC_ESC); end
                else                         send_byte(pay[i]);
            end
            send_byte(SLIP_END);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        check_counters("random");

`ifdef UART_SLIP_MAX_LEN_EN
        // Bytes past MAX_LEN are dropped and the packet is closed as bad.
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b0, 1'b0);
        expect_beat(8'h03, 1'b0, 1'b0);
        expect_beat(8'h04, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_byte(8'hC0);
        drain();
        check_counters("max_len");
`endif

        // Reset in the middle of a stalled packet discards it.
        m_axis_tready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        check("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        exp_pkts = 0;
        exp_errs = 0;
        check_counters("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        beats_before = beats_seen;
        send_byte(8'hC0);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_beats", 32'(beats_seen - beats_before), 0);
        check_counters("post_rst");
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_slip_decoder.md
UART_SLIP_DECODER -- requirements
Module: uart_slip_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1500, max payload bytes per packet (used only with UART_SLIP_MAX_LEN_EN).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port s_axis_tdata  input  8  received byte from UART receiver.
REQ-005 SHALL have port s_axis_tvalid  input  1  byte valid.
REQ-006 SHALL have port s_axis_tready  output  1  byte accepted when high with tvalid.
REQ-007 SHALL have port s_frame_error  input  1  single-cycle UART framing-error pulse.
REQ-008 SHALL have port m_axis_tdata  output  8  decoded payload byte.
REQ-009 SHALL have port m_axis_tvalid, m_axis_tready, m_axis_tlast  output/input/output  1 each  AXI-Stream handshake, last payload byte.
REQ-010 SHALL have port m_axis_tuser  output  1  packet bad, meaningful only with tlast.
REQ-011 SHALL have port busy  output  1  packet in progress (hold register valid or ESCAPE state).
REQ-012 SHALL have ports pkt_count, err_count  output  16 each  packets emitted / bad packets emitted.

Function
REQ-013 SHALL decode SLIP: END 0xC0, ESC 0xDB, ESC_END 0xDC, ESC_ESC 0xDD.
REQ-014 SHALL use states NORMAL and ESCAPE; NORMAL+ESC -> ESCAPE, no byte produced; ESCAPE+any byte -> NORMAL.
REQ-015 ESCAPE+0xDC SHALL produce 0xC0; ESCAPE+0xDD SHALL produce 0xDB; ESCAPE+other byte SHALL produce that byte raw and set packet error flag.
REQ-016 ESCAPE+0xC0 SHALL be treated as END and set packet error flag.
REQ-017 Each produced byte SHALL enter a one-byte hold register; a valid held byte is first pushed to output with tlast=0.
REQ-018 NORMAL+END with hold valid SHALL push held byte with tlast=1, tuser=error flag, then clear flag and hold.
REQ-019 END with hold empty SHALL emit nothing and clear error flag; empty packets are never emitted or counted.
REQ-020 s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready, combinationally.
REQ-021 Output SHALL be registered: one-cycle latency accept-to-tvalid; tdata/tlast/tuser SHALL stay stable while tvalid && !tready.
REQ-022 s_frame_error SHALL set error flag in any cycle regardless of handshake state; if it coincides with END acceptance it SHALL apply to the packet being closed.
REQ-023 pkt_count SHALL increment per tlast beat transferred, err_count per such beat with tuser=1; both wrap 0xFFFF->0.
REQ-024 Input byte arriving while tready low SHALL not be consumed; loss is the upstream's concern.

Reset
REQ-025 On rst_n low SHALL asynchronously clear: m_axis_tvalid, tdata, tlast, tuser, hold, error flag, length counter, counters, state to NORMAL; busy=0.
REQ-026 Reset mid-packet SHALL discard the partial packet with no output.

Configuration
REQ-027 Macro UART_SLIP_MAX_LEN_EN defined: length counter SHALL count bytes produced per packet; bytes beyond MAX_LEN SHALL be discarded and set error flag; packet still closes at END with tuser=1.
REQ-028 Macro undefined: no length counter; packets unbounded; MAX_LEN unused.

Structure
REQ-029 Package uart_slip_pkg SHALL hold SLIP_END, SLIP_ESC, SLIP_ESC_END, SLIP_ESC_ESC constants and the state enum.
REQ-030 SHALL be a single module, no sub-module; hold register and output register inline.

Verification
REQ-031 Bytes 41 42 C0, tready=1 -> beats 41(last0), 42(last1,user0); pkt_count=1.
REQ-032 Bytes DB DC DB DD C0 -> beats C0, DB(last1,user0).
REQ-033 Bytes 10 DB 55 C0 -> beats 10, 55(last1,user1); err_count=1.
REQ-034 Bytes C0 C0 01 C0 -> single beat 01(last1); pkt_count=1.
REQ-035 m_axis_tready held 0 for 5 cycles mid-packet -> s_axis_tready low, output stable, no byte loss; s_frame_error pulse during stall -> closing beat user1.
REQ-036 MAX_LEN=4 with macro, 6 bytes 01..06 then C0 -> beats 01..04, 04 last1 user1; rst_n low mid-packet -> tvalid 0 immediately, no output afterwards.
